mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage RV32I pipeline.
- Uses fixed data-over-fetch priority with an anti-starvation override.
- Allows one outstanding transaction and returns each response to the requester that issued it.
- Produces per-requester stall indications that the pipeline uses to freeze the PC and pipeline registers.

---
 rtl/riscv_mem_pkg.sv | 10 +
 rtl/mem_port_arbiter_perf_counters.sv | 27 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_perf_counters.sv
// Grant and conflict event counters for the memory port arbiter; only
// instantiated when ARB_PERF_CNT_EN is defined.
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        grant_if,
    input  logic        grant_dm,
    input  logic        conflict,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_dm_grants,
    output logic [31:0] perf_conflict
);

    // Counters wrap modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_grants <= '0;
            perf_dm_grants <= '0;
            perf_conflict  <= '0;
        end else begin
            if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_dm) perf_dm_grants <= perf_dm_grants + 32'd1;
            if (conflict) perf_conflict  <= perf_conflict + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM data access: data-over-fetch
// priority with anti-starvation, one outstanding transaction. Optional ARB_PERF_CNT_EN.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                dm_req_valid,
    input  logic                dm_req_we,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic [DATA_W-1:0]   dm_req_wdata,
    input  logic [DATA_W/8-1:0] dm_req_be,
    output logic                dm_req_ready,
    output logic                dm_rsp_valid,
    output logic [DATA_W-1:0]   dm_rsp_data,
    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                stall_if,
    output logic                stall_dm,
    output logic                busy,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_dm_grants,
    output logic [31:0]         perf_conflict
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    arb_state_t          state, state_nxt;
    owner_e              owner;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;
    logic [SC_W-1:0]     starve_cnt;
    logic                grant_if, grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Fetch only wins a contested IDLE cycle once data has been granted STARVE_MAX times.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        case (state)
            IDLE: begin
                grant_if = if_req_valid & (~dm_req_valid | (starve_cnt == STARVE_LIM));
                grant_dm = dm_req_valid & ~grant_if;
                if (grant_if | grant_dm) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (mem_req_ready) state_nxt = lat_we ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (grant_if) begin
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_addr  <= if_req_addr;
            lat_wdata <= '0;
            lat_be    <= '1;
        end else if (grant_dm) begin
            owner     <= OWN_DM;
            lat_we    <= dm_req_we;
            lat_addr  <= dm_req_addr;
            lat_wdata <= dm_req_wdata;
            lat_be    <= dm_req_we ? dm_req_be : '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_if)
            starve_cnt <= '0;
        else if (grant_dm && if_req_valid && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    // Responses are registered; data holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            if (state == ISSUE && mem_req_ready && lat_we) begin
                dm_rsp_valid <= 1'b1;
                dm_rsp_data  <= '0;
            end
            if (state == WAIT_RSP && mem_rsp_valid) begin
                if (owner == OWN_IF) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= mem_rsp_data;
                end else begin
                    dm_rsp_valid <= 1'b1;
                    dm_rsp_data  <= mem_rsp_data;
                end
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign dm_req_ready  = grant_dm;
    assign mem_req_valid = (state == ISSUE);
    assign mem_req_we    = lat_we;
    assign mem_req_addr  = lat_addr;
    assign mem_req_wdata = lat_wdata;
    assign mem_req_be    = lat_be;
    assign stall_if      = if_req_valid & ~if_req_ready;
    assign stall_dm      = dm_req_valid & ~dm_req_ready;
    assign busy          = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters u_perf (
        .clk            (clk),
        .rst            (rst),
        .grant_if       (grant_if),
        .grant_dm       (grant_dm),
        .conflict       ((state == IDLE) & if_req_valid & dm_req_valid),
        .perf_if_grants (perf_if_grants),
        .perf_dm_grants (perf_dm_grants),
        .perf_conflict  (perf_conflict)
    );
`else
    assign perf_if_grants = '0;
    assign perf_dm_grants = '0;
    assign perf_conflict  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: inputs driven at negedge, outputs sampled 1ns later.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready, if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid, dm_req_we;
    logic [31:0] dm_req_addr, dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_req_ready, dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        stall_if, stall_dm, busy;
    logic [31:0] perf_if_grants, perf_dm_grants, perf_conflict;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .stall_if(stall_if), .stall_dm(stall_dm), .busy(busy),
        .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants), .perf_conflict(perf_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic inputs_idle();
        if_req_valid = 0; if_req_addr = 0;
        dm_req_valid = 0; dm_req_we = 0; dm_req_addr = 0; dm_req_wdata = 0; dm_req_be = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inputs_idle();
        cyc(); cyc(); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b want 0", busy); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_valid got %0b want 0", mem_req_valid); end
        vectors++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 00", {if_rsp_valid, dm_rsp_valid}); end
        vectors++; if (mem_req_be !== 4'h0) begin miscompares++; $display("FAIL rst_mem_req_be got %h want 0", mem_req_be); end
        cyc(); rst = 1'b0;
    endtask

    // Both requesters continuously valid, zero-wait memory: DM x4 then IF, repeated.
    task automatic test_starvation();
        logic exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int g = 0; g < 10; g++) begin
            cyc();
            if_req_valid = 1; if_req_addr = 32'h1000;
            dm_req_valid = 1; dm_req_we = 0; dm_req_addr = 32'h2000;
            mem_req_ready = 1; mem_rsp_valid = 0;
            #1;
            vectors++; if ({if_req_ready, dm_req_ready} !== {exp_if[g], ~exp_if[g]}) begin miscompares++; $display("FAIL starve_grant%0d got if=%0b dm=%0b want if=%0b", g, if_req_ready, dm_req_ready, exp_if[g]); end
            if (g > 0) begin
                vectors++;
                if ((exp_if[g-1] ? if_rsp_data : dm_rsp_data) !== 32'(g - 1) || (exp_if[g-1] ? if_rsp_valid : dm_rsp_valid) !== 1'b1) begin
                    miscompares++; $display("FAIL starve_rsp%0d got if=%0b/%h dm=%0b/%h want data %h", g - 1, if_rsp_valid, if_rsp_data, dm_rsp_valid, dm_rsp_data, g - 1);
                end
            end
            cyc();
            cyc(); mem_rsp_valid = 1; mem_rsp_data = 32'(g);
        end
        cyc(); inputs_idle(); #1;
        vectors++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'd9) begin miscompares++; $display("FAIL starve_last_rsp got %0b/%h want 1/9", if_rsp_valid, if_rsp_data); end
`ifdef ARB_PERF_CNT_EN
        vectors++; if ({perf_conflict, perf_if_grants, perf_dm_grants} !== {32'd10, 32'd2, 32'd8}) begin miscompares++; $display("FAIL perf_counts got c=%0d if=%0d dm=%0d want 10/2/8", perf_conflict, perf_if_grants, perf_dm_grants); end
`else
        vectors++; if ({perf_conflict, perf_if_grants, perf_dm_grants} !== 96'd0) begin miscompares++; $display("FAIL perf_tied got c=%0d if=%0d dm=%0d want 0/0/0", perf_conflict, perf_if_grants, perf_dm_grants); end
`endif
    endtask

    task automatic test_single_fetch();
        cyc(); if_req_valid = 1; if_req_addr = 32'h10; mem_req_ready = 1; mem_rsp_data = 32'h13; #1;
        vectors++; if (if_req_ready !== 1'b1 || stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_ready got rdy=%0b stall=%0b want 1/0", if_req_ready, stall_if); end
        cyc(); if_req_valid = 0; #1;
        vectors++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin miscompares++; $display("FAIL fetch_issue got v=%0b we=%0b a=%h be=%h want 1/0/10/f", mem_req_valid, mem_req_we, mem_req_addr, mem_req_be); end
        cyc(); mem_rsp_valid = 1; #1;
        vectors++; if (if_rsp_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL fetch_wait got rsp=%0b busy=%0b want 0/1", if_rsp_valid, busy); end
        cyc(); mem_rsp_valid = 0; #1;
        vectors++; if ({if_rsp_valid, if_rsp_data, dm_rsp_valid, busy} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin miscompares++; $display("FAIL fetch_rsp got v=%0b d=%h dmv=%0b busy=%0b want 1/13/0/0", if_rsp_valid, if_rsp_data, dm_rsp_valid, busy); end
        cyc(); #1;
        vectors++; if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h13) begin miscompares++; $display("FAIL fetch_hold got v=%0b d=%h want 0/13", if_rsp_valid, if_rsp_data); end
    endtask

    task automatic test_contested();
        cyc(); if_req_valid = 1; if_req_addr = 32'h40; dm_req_valid = 1; dm_req_we = 0; dm_req_addr = 32'h100;
        mem_req_ready = 1; mem_rsp_data = 32'hCAFE0001; #1;
        vectors++; if ({dm_req_ready, if_req_ready, stall_if, stall_dm} !== 4'b1010) begin miscompares++; $display("FAIL cont_grant got dm=%0b if=%0b sif=%0b sdm=%0b want 1/0/1/0", dm_req_ready, if_req_ready, stall_if, stall_dm); end
        cyc(); dm_req_valid = 0; #1;
        vectors++; if (mem_req_addr !== 32'h100 || stall_if !== 1'b1) begin miscompares++; $display("FAIL cont_issue got a=%h sif=%0b want 100/1", mem_req_addr, stall_if); end
        cyc(); mem_rsp_valid = 1; #1;
        vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL cont_stall_wait got %0b want 1", stall_if); end
        cyc(); mem_rsp_valid = 0; #1;
        vectors++; if ({dm_rsp_valid, dm_rsp_data, if_rsp_valid} !== {1'b1, 32'hCAFE0001, 1'b0}) begin miscompares++; $display("FAIL cont_dm_rsp got v=%0b d=%h ifv=%0b want 1/cafe0001/0", dm_rsp_valid, dm_rsp_data, if_rsp_valid); end
        vectors++; if (if_req_ready !== 1'b1 || stall_if !== 1'b0) begin miscompares++; $display("FAIL cont_if_grant got rdy=%0b stall=%0b want 1/0", if_req_ready, stall_if); end
        cyc(); if_req_valid = 0; #1;
        vectors++; if (mem_req_addr !== 32'h40) begin miscompares++; $display("FAIL cont_if_addr got %h want 40", mem_req_addr); end
        cyc(); mem_rsp_valid = 1; mem_rsp_data = 32'h93;
        cyc(); mem_rsp_valid = 0; #1;
        vectors++; if ({if_rsp_valid, if_rsp_data, dm_rsp_valid} !== {1'b1, 32'h93, 1'b0}) begin miscompares++; $display("FAIL cont_if_rsp got v=%0b d=%h dmv=%0b want 1/93/0", if_rsp_valid, if_rsp_data, dm_rsp_valid); end
    endtask

    task automatic test_store();
        cyc(); dm_req_valid = 1; dm_req_we = 1; dm_req_addr = 32'h200; dm_req_wdata = 32'hDEADBEEF; dm_req_be = 4'h3;
        mem_req_ready = 0; #1;
        vectors++; if (dm_req_ready !== 1'b1) begin miscompares++; $display("FAIL store_ready got %0b want 1", dm_req_ready); end
        cyc(); dm_req_valid = 0; dm_req_we = 0;
        for (int k = 0; k < 3; k++) begin
            mem_req_ready = (k == 2); #1;
            vectors++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be} !== {1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3}) begin
                miscompares++; $display("FAIL store_hold%0d got v=%0b we=%0b a=%h d=%h be=%h", k, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be);
            end
            cyc();
        end
        mem_req_ready = 0; #1;
        vectors++; if ({dm_rsp_valid, dm_rsp_data, if_rsp_valid, mem_req_valid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL store_done got v=%0b d=%h ifv=%0b mv=%0b want 1/0/0/0", dm_rsp_valid, dm_rsp_data, if_rsp_valid, mem_req_valid); end
        cyc(); #1;
        vectors++; if (dm_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL store_pulse got dmv=%0b ifv=%0b want 0/0", dm_rsp_valid, if_rsp_valid); end
    endtask

    task automatic test_reset_inflight();
        cyc(); if_req_valid = 1; if_req_addr = 32'h80; mem_req_ready = 1;
        cyc(); if_req_valid = 0;
        cyc(); #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL inflight_busy got %0b want 1", busy); end
        rst = 1; #1;
        vectors++; if ({busy, mem_req_valid, if_rsp_valid, dm_rsp_valid} !== 4'b0000) begin miscompares++; $display("FAIL inflight_rst_ctl got busy=%0b mv=%0b ifv=%0b dmv=%0b want 0", busy, mem_req_valid, if_rsp_valid, dm_rsp_valid); end
        vectors++; if ({if_rsp_data, dm_rsp_data, mem_req_addr} !== 96'd0) begin miscompares++; $display("FAIL inflight_rst_data got if=%h dm=%h a=%h want 0", if_rsp_data, dm_rsp_data, mem_req_addr); end
        cyc(); rst = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h55;
        cyc(); mem_rsp_valid = 0; if_req_valid = 1; if_req_addr = 32'h84; #1;
        vectors++; if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL late_rsp got ifv=%0b dmv=%0b want 0/0", if_rsp_valid, dm_rsp_valid); end
        vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %0b want 1", if_req_ready); end
        cyc(); if_req_valid = 0; #1;
        vectors++; if (mem_req_addr !== 32'h84 || mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_issue got a=%h v=%0b want 84/1", mem_req_addr, mem_req_valid); end
        cyc(); mem_rsp_valid = 1; mem_rsp_data = 32'h66;
        cyc(); mem_rsp_valid = 0; #1;
        vectors++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h66) begin miscompares++; $display("FAIL post_rst_rsp got v=%0b d=%h want 1/66", if_rsp_valid, if_rsp_data); end
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_single_fetch();
        test_contested();
        test_store();
        test_reset_inflight();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
